clock_set_ctrl: RTL

Single-clock controller for the mm:ss digital clock datapath. It owns the four BCD time digits, advances them from a 1 Hz enable pulse, and sequences a time-setting mode driven by two debounced push-buttons (mode, increment). It sits between the clock divider (which supplies `tick_1hz`) and the four 7-segment decoders, replacing the ripple-clocked counter chain with one synchronous state machine.

---
 rtl/clock_ctrl_pkg.sv | 20 ++
 rtl/bcd60_inc.sv | 39 +++
 rtl/clock_set_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg
// Shared types and constants for the mm:ss clock controller.
//   mode_t        : controller state (RUN, SET_MIN, SET_SEC)
//   UNITS_W/TENS_W: digit widths for BCD units and tens digits
//   UNITS_MAX/TENS_MAX: highest legal units/tens value for a mod-60 digit pair
package clock_ctrl_pkg;

   localparam int UNITS_W = 4;
   localparam int TENS_W  = 3;

   localparam logic [UNITS_W-1:0] UNITS_MAX = 4'd9;
   localparam logic [TENS_W-1:0]  TENS_MAX  = 3'd5;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_MIN = 2'd1,
      SET_SEC = 2'd2
   } mode_t;

endpackage

// File: rtl/bcd60_inc.sv
// bcd60_inc
// Combinational two-digit BCD mod-60 incrementer.
//   inc_i   : add one when high, pass through when low
//   units_i : current units digit (0-9)
//   tens_i  : current tens digit (0-5)
//   units_o : next units digit
//   tens_o  : next tens digit
//   wrap_o  : high when an increment wraps 59 -> 00
module bcd60_inc
   import clock_ctrl_pkg::*;
(
   input  logic               inc_i,
   input  logic [UNITS_W-1:0] units_i,
   input  logic [TENS_W-1:0]  tens_i,
   output logic [UNITS_W-1:0] units_o,
   output logic [TENS_W-1:0]  tens_o,
   output logic               wrap_o
);

   always_comb begin
      units_o = units_i;
      tens_o  = tens_i;
      wrap_o  = 1'b0;
      if (inc_i) begin
         if (units_i == UNITS_MAX) begin
            units_o = '0;
            if (tens_i == TENS_MAX) begin
               tens_o = '0;
               wrap_o = 1'b1;
            end else begin
               tens_o = tens_i + 1'b1;
            end
         end else begin
            units_o = units_i + 1'b1;
         end
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// mm:ss clock controller: owns the four BCD digits, advances them on tick_1hz
// in RUN, and lets the user set minutes/seconds with mode/increment buttons.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   tick_1hz  : one-cycle enable, once per second
//   btn_mode  : debounced mode button level (high = pressed)
//   btn_inc   : debounced increment button level (high = pressed)
//   sec_units, sec_tens, min_units, min_tens : registered time digits
//   mode      : controller state (0 RUN, 1 SET_MIN, 2 SET_SEC)
//   carry_1h  : one-cycle pulse on 59:59 -> 00:00
//   blank     : per-digit blank request ([0] sec_units .. [3] min_tens)
// Build option: define CLOCK_SET_BLINK_EN to build the blink counter; without
// it blank is constant zero and BLINK_HALF has no effect.
module clock_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int BLINK_HALF = 25_000_000
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               tick_1hz,
   input  logic               btn_mode,
   input  logic               btn_inc,
   output logic [UNITS_W-1:0] sec_units,
   output logic [TENS_W-1:0]  sec_tens,
   output logic [UNITS_W-1:0] min_units,
   output logic [TENS_W-1:0]  min_tens,
   output logic [1:0]         mode,
   output logic               carry_1h,
   output logic [3:0]         blank
);

   mode_t              mode_q, mode_d;
   logic               btn_mode_prev_q, btn_inc_prev_q;
   logic [UNITS_W-1:0] sec_units_q, sec_units_d, min_units_q, min_units_d;
   logic [TENS_W-1:0]  sec_tens_q, sec_tens_d, min_tens_q, min_tens_d;
   logic               carry_q, carry_d;

   logic mode_press, inc_press, inc_ok;
   logic sec_inc, min_inc, sec_wrap, min_wrap;

   // History registers reset to 1 so a button held through reset release
   // does not look like a fresh press.
   assign mode_press = btn_mode & ~btn_mode_prev_q;
   assign inc_press  = btn_inc & ~btn_inc_prev_q;
   // A mode press in the same cycle swallows the increment.
   assign inc_ok     = inc_press & ~mode_press;

   assign sec_inc = ((mode_q == RUN) & tick_1hz) | ((mode_q == SET_SEC) & inc_ok);
   // In RUN minutes follow the seconds wrap; in SET_MIN only the button moves them.
   assign min_inc = ((mode_q == RUN) & sec_wrap) | ((mode_q == SET_MIN) & inc_ok);

   bcd60_inc u_sec_inc (
      .inc_i   (sec_inc),
      .units_i (sec_units_q),
      .tens_i  (sec_tens_q),
      .units_o (sec_units_d),
      .tens_o  (sec_tens_d),
      .wrap_o  (sec_wrap)
   );

   bcd60_inc u_min_inc (
      .inc_i   (min_inc),
      .units_i (min_units_q),
      .tens_i  (min_tens_q),
      .units_o (min_units_d),
      .tens_o  (min_tens_d),
      .wrap_o  (min_wrap)
   );

   always_comb begin
      mode_d = mode_q;
      case (mode_q)
         RUN:     if (mode_press) mode_d = SET_MIN;
         SET_MIN: if (mode_press) mode_d = SET_SEC;
         SET_SEC: if (mode_press) mode_d = RUN;
         default: mode_d = RUN;
      endcase
      // Minutes only wrap in RUN when seconds wrapped too: that is 59:59 -> 00:00.
      carry_d = (mode_q == RUN) & min_wrap;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q          <= RUN;
         btn_mode_prev_q <= 1'b1;
         btn_inc_prev_q  <= 1'b1;
         sec_units_q     <= '0;
         sec_tens_q      <= '0;
         min_units_q     <= '0;
         min_tens_q      <= '0;
         carry_q         <= 1'b0;
      end else begin
         mode_q          <= mode_d;
         btn_mode_prev_q <= btn_mode;
         btn_inc_prev_q  <= btn_inc;
         sec_units_q     <= sec_units_d;
         sec_tens_q      <= sec_tens_d;
         min_units_q     <= min_units_d;
         min_tens_q      <= min_tens_d;
         carry_q         <= carry_d;
      end
   end

   assign sec_units = sec_units_q;
   assign sec_tens  = sec_tens_q;
   assign min_units = min_units_q;
   assign min_tens  = min_tens_q;
   assign mode      = mode_q;
   assign carry_1h  = carry_q;

`ifdef CLOCK_SET_BLINK_EN
   localparam int CNT_W = ($clog2(BLINK_HALF) < 1) ? 1 : $clog2(BLINK_HALF);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             phase_q, phase_d;
   logic [3:0]       blank_q, blank_d;
   logic             blink_clr;

   // Restart from the visible phase when a set mode is entered or the value
   // changes, so the digit being edited is shown right after each edit.
   assign blink_clr = ((mode_d != mode_q) & (mode_d != RUN)) | inc_press;

   always_comb begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
      blank_d     = 4'b0000;
      if (blink_clr) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (blink_cnt_q == CNT_LAST) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
      if (mode_d == SET_MIN) blank_d[3:2] = {2{phase_d}};
      if (mode_d == SET_SEC) blank_d[1:0] = {2{phase_d}};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         blank_q     <= 4'b0000;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         blank_q     <= blank_d;
      end
   end

   assign blank = blank_q;
`else
   logic blink_half_unused;
   assign blink_half_unused = |BLINK_HALF;
   assign blank = 4'b0000;
`endif

endmodule
